regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Single owner of the register-file write port. Merges main-pipeline writeback and
//  out-of-order results returned by the scan accelerator over a valid/ready channel.
//  Buffers accelerator results in a small FIFO. Keeps a per-register busy scoreboard
//  so decode can stall on registers that still have an accelerator result pending.
// PARAMETERS
//  DEPTH       4   accelerator result FIFO entries (power of 2, >=2)
//  STARVE_MAX  8   consecutive blocked cycles before stall_req is raised
// PORTS
//  clk_cpu       in   1    CPU clock
//  reset         in   1    asynchronous, active-high
//  pipe_wr_en    in   1    pipeline writeback valid (always accepted, highest priority)
//  pipe_wr_adrs  in   5    pipeline destination register
//  pipe_wr_data  in   32   pipeline result
//  acc_valid     in   1    accelerator result valid
//  acc_ready     out  1    arbiter can accept an accelerator result
//  acc_adrs      in   5    accelerator destination register
//  acc_data      in   32   accelerator result
//  issue_en      in   1    decode issued an accelerator op; mark issue_adrs busy
//  issue_adrs    in   5    destination register of the issued op
//  busy_vec      out  32   scoreboard, bit i = register i awaiting accelerator result
//  stall_req     out  1    pipeline must hold pipe_wr_en low to drain FIFO
//  fifo_count    out  $clog2(DEPTH+1)  current FIFO occupancy
//  rf_wr_en      out  1    register-file write enable
//  rf_wr_adrs    out  5    register-file write address
//  rf_wr_data    out  32   register-file write data
// BEHAVIOUR
//  Reset (async): rf_wr_en=0, rf_wr_adrs=0, rf_wr_data=0, busy_vec=0, stall_req=0,
//   FIFO emptied (fifo_count=0), starvation counter=0. acc_ready=1 after reset.
//   Reset mid-operation discards all queued results. The accelerator is reset together.
//  rf_wr_* are registered and change only on clk_cpu edges.
//  Per-edge selection for rf_wr_*:
//   1) pipe_wr_en=1: rf_wr_* <= pipe values. rf_wr_en = (pipe_wr_adrs!=0).
//   2) else FIFO non-empty: pop head, rf_wr_en<=1, rf_wr_* <= head.
//   3) else rf_wr_en<=0. adrs and data hold their previous values.
//  Latency: pipe write is visible on rf_wr_* 1 cycle after it is presented.
//   An accelerator result accepted at edge N is pushed at N.
//   It is popped at the earliest edge >=N+1 with no pipe write.
//  Handshake: a transfer occurs when acc_valid && acc_ready at an edge.
//   acc_ready = (fifo_count < DEPTH), derived from state only.
//   When full, no push is accepted even if a pop occurs the same cycle.
//   acc_adrs and acc_data must stay stable while acc_valid && !acc_ready.
//   An accepted result with acc_adrs==0 is consumed but not enqueued.
//  Scoreboard:
//   issue_en sets busy[issue_adrs] at the edge. issue_adrs==0 is ignored.
//   A FIFO pop clears busy[head.adrs].
//   If set and clear hit the same address in the same cycle, set wins.
//   A pipe write never clears busy. Decode must not issue a pipeline write to a busy register.
//  Starvation:
//   The counter increments on each cycle with FIFO non-empty and pipe_wr_en=1.
//   It clears on any pop or when the FIFO is empty.
//   stall_req <= (counter >= STARVE_MAX-1). It drops the cycle after a pop.
//   pipe_wr_en while stall_req=1 still wins. This is a contract violation, flagged by an assertion.
//  Busy bits are count-free: at most one outstanding accelerator op per register.
// STRUCTURE
//  N_REGS, REG_W (32) and ADRS_W (5) come from the shared defines header.
//  Typedef wb_entry_t {adrs[4:0], data[31:0]} goes in the shared cpu_pkg.
//  Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push, pop, count,
//   full and empty outputs, and async reset.
//  Arbitration, scoreboard and starvation logic stay in this module.
// TESTING
//  Reset with pipe_wr_en=1 asserted -> all outputs 0 during reset.
//   acc_ready=1 and busy_vec=0 after release.
//  pipe write $5=0x1234 -> next cycle rf_wr_en=1, adrs=5, data=0x1234.
//   pipe write $0 -> rf_wr_en=0.
//  issue $8, then acc result $8=0xCAFE with pipe idle -> busy[8]=1 until the pop edge.
//   rf write of $8=0xCAFE occurs 1 cycle after acceptance.
//  Continuous pipe writes while 4 acc results are pushed -> acc_ready=0 at count 4.
//   stall_req rises after 8 blocked cycles.
//   Pipe idle -> entries drain in FIFO order, one per cycle.
//  Same-cycle issue $3 and pop of an entry for $3 -> busy[3] stays 1.
//  Async reset asserted with FIFO count 3 -> FIFO empties immediately.
//   No rf write of the queued entries occurs after release.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared CPU register-file widths and the writeback entry format.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_write_arbiter_pkg;

    localparam int N_REGS = 32;
    localparam int REG_W  = 32;
    localparam int ADRS_W = 5;

    typedef struct packed {
        logic [ADRS_W-1:0] adrs;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Synchronous FIFO of writeback entries; head is visible combinationally.
// Latency: a pushed entry is visible at the head after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_cpu,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_cpu) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on overflow.
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole owner of the register-file write port: pipeline writeback first, queued accelerator results otherwise.
// Latency: 1 cycle pipe->rf; accelerator result popped at the first pipe-idle edge after acceptance.
// Backpressure: acc_ready drops when the FIFO is full; stall_req asks the pipeline to yield after starvation.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk_cpu,
    input  logic                       reset,
    input  logic                       pipe_wr_en,
    input  logic [ADRS_W-1:0]          pipe_wr_adrs,
    input  logic [REG_W-1:0]           pipe_wr_data,
    input  logic                       acc_valid,
    output logic                       acc_ready,
    input  logic [ADRS_W-1:0]          acc_adrs,
    input  logic [REG_W-1:0]           acc_data,
    input  logic                       issue_en,
    input  logic [ADRS_W-1:0]          issue_adrs,
    output logic [N_REGS-1:0]          busy_vec,
    output logic                       stall_req,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       rf_wr_en,
    output logic [ADRS_W-1:0]          rf_wr_adrs,
    output logic [REG_W-1:0]           rf_wr_data
);

    localparam int STV_W = $clog2(STARVE_MAX + 1);

    wb_entry_t          acc_entry;
    wb_entry_t          head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [STV_W-1:0]   starve_cnt;
    logic [N_REGS-1:0]  busy_nxt;

    assign acc_ready = !fifo_full;
    assign acc_entry = '{adrs: acc_adrs, data: acc_data};
    // Results for $0 complete the handshake but never reach the FIFO.
    assign push      = acc_valid && acc_ready && (acc_adrs != '0);
    assign pop       = !pipe_wr_en && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .push       (push),
        .push_entry (acc_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            rf_wr_en   <= 1'b0;
            rf_wr_adrs <= '0;
            rf_wr_data <= '0;
        end else if (pipe_wr_en) begin
            rf_wr_en   <= (pipe_wr_adrs != '0);
            rf_wr_adrs <= pipe_wr_adrs;
            rf_wr_data <= pipe_wr_data;
        end else if (!fifo_empty) begin
            rf_wr_en   <= 1'b1;
            rf_wr_adrs <= head.adrs;
            rf_wr_data <= head.data;
        end else begin
            rf_wr_en   <= 1'b0;
        end
    end

    // Issue is applied after the pop clear so a same-cycle set wins.
    always_comb begin
        busy_nxt = busy_vec;
        if (pop) begin
            busy_nxt[head.adrs] = 1'b0;
        end
        if (issue_en && (issue_adrs != '0)) begin
            busy_nxt[issue_adrs] = 1'b1;
        end
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

    // Non-empty without a pop implies a pipe write took the port.
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STV_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            stall_req <= (starve_cnt >= STV_W'(STARVE_MAX - 1));
        end
    end

    a_no_pipe_write_during_stall: assert property (
        @(posedge clk_cpu) disable iff (reset) !(pipe_wr_en && stall_req)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus fill/starve/drain and async-reset sequences.
// Latency: outputs sampled 1 time unit after each rising clk_cpu edge.
// Backpressure: accelerator valid held steady while not ready.
module tb_regfile_write_arbiter;

    logic        clk_cpu;
    logic        reset;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_adrs;
    logic [31:0] pipe_wr_data;
    logic        acc_valid;
    logic        acc_ready;
    logic [4:0]  acc_adrs;
    logic [31:0] acc_data;
    logic        issue_en;
    logic [4:0]  issue_adrs;
    logic [31:0] busy_vec;
    logic        stall_req;
    logic [2:0]  fifo_count;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_adrs;
    logic [31:0] rf_wr_data;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_wr_adrs (pipe_wr_adrs),
        .pipe_wr_data (pipe_wr_data),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .acc_adrs     (acc_adrs),
        .acc_data     (acc_data),
        .issue_en     (issue_en),
        .issue_adrs   (issue_adrs),
        .busy_vec     (busy_vec),
        .stall_req    (stall_req),
        .fifo_count   (fifo_count),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_adrs   (rf_wr_adrs),
        .rf_wr_data   (rf_wr_data)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        logic        pe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        ie;
        logic [4:0]  ia;
        logic        ren;
        logic [4:0]  radr;
        logic [31:0] rdat;
        logic [31:0] busy;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                                input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic ie, input logic [4:0] ia,
                                input logic ren, input logic [4:0] radr, input logic [31:0] rdat,
                                input logic [31:0] busy, input logic [2:0] cnt);
        vec_t v;
        v.pe = pe; v.pa = pa; v.pd = pd;
        v.av = av; v.aa = aa; v.ad = ad;
        v.ie = ie; v.ia = ia;
        v.ren = ren; v.radr = radr; v.rdat = rdat;
        v.busy = busy; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic drive(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic ie, input logic [4:0] ia);
        pipe_wr_en = pe; pipe_wr_adrs = pa; pipe_wr_data = pd;
        acc_valid  = av; acc_adrs     = aa; acc_data     = ad;
        issue_en   = ie; issue_adrs   = ia;
    endtask

    task automatic check_rf(input string tag, input logic en, input logic [4:0] adrs, input logic [31:0] data);
        check({tag, ".rf_wr_en"},   64'(rf_wr_en),   64'(en));
        check({tag, ".rf_wr_adrs"}, 64'(rf_wr_adrs), 64'(adrs));
        check({tag, ".rf_wr_data"}, 64'(rf_wr_data), 64'(data));
    endtask

    initial begin
        // Reset while the pipeline is trying to write.
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        step();
        step();
        check_rf("rst", 1'b0, 5'd0, 32'h0);
        check("rst.busy_vec",   64'(busy_vec),   64'h0);
        check("rst.stall_req",  64'(stall_req),  64'h0);
        check("rst.fifo_count", 64'(fifo_count), 64'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #2 reset = 1'b0;
        #1;
        check("post_rst.acc_ready", 64'(acc_ready), 64'h1);
        check("post_rst.busy_vec",  64'(busy_vec),  64'h0);

        //              pe  pa     pd             av  aa     ad             ie  ia     ren  radr   rdat           busy       cnt
        vecs[0]  = mk(1, 5'd5, 32'h1234,     0, 5'd0, 32'h0,        0, 5'd0, 1, 5'd5, 32'h1234,     32'h0,     3'd0);
        vecs[1]  = mk(1, 5'd0, 32'h9999,     0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd0, 32'h9999,     32'h0,     3'd0);
        vecs[2]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd8, 0, 5'd0, 32'h9999,     32'h100,   3'd0);
        vecs[3]  = mk(0, 5'd0, 32'h0,        1, 5'd8, 32'hCAFE,     0, 5'd0, 0, 5'd0, 32'h9999,     32'h100,   3'd1);
        vecs[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 1, 5'd8, 32'hCAFE,     32'h0,     3'd0);
        vecs[5]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd8, 32'hCAFE,     32'h0,     3'd0);
        vecs[6]  = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'hDEAD,     0, 5'd0, 0, 5'd8, 32'hCAFE,     32'h0,     3'd0);
        vecs[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd8, 32'hCAFE,     32'h0,     3'd0);
        vecs[8]  = mk(1, 5'd4, 32'h44,       1, 5'd3, 32'h33,       1, 5'd3, 1, 5'd4, 32'h44,       32'h8,     3'd1);
        vecs[9]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd3, 1, 5'd3, 32'h33,       32'h8,     3'd0);
        vecs[10] = mk(0, 5'd0, 32'h0,        1, 5'd3, 32'h55,       0, 5'd0, 0, 5'd3, 32'h33,       32'h8,     3'd1);
        vecs[11] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 1, 5'd3, 32'h55,       32'h0,     3'd0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pe, vecs[i].pa, vecs[i].pd, vecs[i].av, vecs[i].aa, vecs[i].ad,
                  vecs[i].ie, vecs[i].ia);
            step();
            check_rf($sformatf("v%0d", i), vecs[i].ren, vecs[i].radr, vecs[i].rdat);
            check($sformatf("v%0d.busy_vec", i),   64'(busy_vec),   64'(vecs[i].busy));
            check($sformatf("v%0d.fifo_count", i), 64'(fifo_count), 64'(vecs[i].cnt));
            check($sformatf("v%0d.stall_req", i),  64'(stall_req),  64'h0);
        end

        // Fill under continuous pipe writes; a fifth result waits while full.
        for (int e = 1; e <= 9; e++) begin
            if (e <= 4) drive(1'b1, 5'(10 + e), 32'(e), 1'b1, 5'(19 + e), 32'(32'hA0 + e - 1), 1'b0, 5'd0);
            else        drive(1'b1, 5'(10 + e), 32'(e), 1'b1, 5'd24, 32'hA4, 1'b0, 5'd0);
            step();
            if (e == 4) begin
                check("fill.count4", 64'(fifo_count), 64'd4);
                check("fill.acc_ready_full", 64'(acc_ready), 64'h0);
            end
            if (e == 8) check("starve.stall_before", 64'(stall_req), 64'h0);
        end
        check("starve.stall_rise", 64'(stall_req), 64'h1);
        check("starve.count", 64'(fifo_count), 64'd4);
        check_rf("starve.pipe", 1'b1, 5'd19, 32'd9);

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'hA4, 1'b0, 5'd0);
        step();
        check_rf("drain0", 1'b1, 5'd20, 32'hA0);
        check("drain0.no_push_when_full", 64'(fifo_count), 64'd3);
        check("drain0.stall_held", 64'(stall_req), 64'h1);
        acc_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            step();
            check_rf($sformatf("drain%0d", k), 1'b1, 5'(20 + k), 32'(32'hA0 + k));
            check($sformatf("drain%0d.count", k), 64'(fifo_count), 64'(3 - k));
            check($sformatf("drain%0d.stall", k), 64'(stall_req), 64'h0);
        end
        step();
        check("drain.idle_en", 64'(rf_wr_en), 64'h0);

        // Async reset with three entries queued.
        for (int e = 0; e < 3; e++) begin
            drive(1'b1, 5'd1, 32'h11, 1'b1, 5'(25 + e), 32'(32'hB0 + e), (e == 0), 5'd9);
            step();
        end
        check("arst.pre_count", 64'(fifo_count), 64'd3);
        check("arst.pre_busy",  64'(busy_vec),   64'h200);
        acc_valid = 1'b0;
        issue_en  = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst.count",     64'(fifo_count), 64'd0);
        check("arst.acc_ready", 64'(acc_ready),  64'h1);
        check("arst.busy",      64'(busy_vec),   64'h0);
        check_rf("arst", 1'b0, 5'd0, 32'h0);
        step();
        step();
        check("arst.held_en", 64'(rf_wr_en), 64'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("arst.after%0d.en", k),    64'(rf_wr_en),   64'h0);
            check($sformatf("arst.after%0d.count", k), 64'(fifo_count), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
